// File: rtl/count_capture_ctrl_if.sv
// Command, read-port and status bundle for the count capture sequencer.
// The master side issues start/abort and reads; the slave side is the sequencer.
interface count_capture_ctrl_if #(
  parameter int CNT_W = 8,
  parameter int PTR_W = 4
);
  logic             cfg_start;
  logic             cfg_abort;
  logic [CNT_W-1:0] cfg_trig_val;
  logic [PTR_W:0]   cfg_len;
  logic             rd_en;
  logic [PTR_W-1:0] rd_addr;
  logic [CNT_W-1:0] rd_data;
  logic             rd_valid;
  logic [CNT_W-1:0] count;
  logic [PTR_W:0]   cap_len;
  logic             busy;
  logic             done;
  logic             cnt_end;

  modport master (
    output cfg_start, cfg_abort, cfg_trig_val, cfg_len, rd_en, rd_addr,
    input  rd_data, rd_valid, count, cap_len, busy, done, cnt_end
  );

  modport slave (
    input  cfg_start, cfg_abort, cfg_trig_val, cfg_len, rd_en, rd_addr,
    output rd_data, rd_valid, count, cap_len, busy, done, cnt_end
  );
endinterface

// File: rtl/count_capture_ctrl.sv
// Capture sequencer: runs a free-running counter, waits for a trigger value,
// then records a programmed number of consecutive samples into a small RAM.
module count_capture_ctrl #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  count_capture_ctrl_if.slave bus
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [PTR_W:0]   LEN_MAX = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   LEN_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] trig_reg, trig_next;
  logic [PTR_W:0]   len_reg, len_next;
  logic [PTR_W:0]   cap_len_reg, cap_len_next;
  logic [PTR_W:0]   cap_len_inc;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic             done_reg, done_next;
  logic             cnt_end_reg, cnt_end_next;
  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;

  logic [CNT_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0] rd_data_reg;
  logic             rd_valid_reg;

  assign cap_len_inc = cap_len_reg + 1'b1;

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    trig_next    = trig_reg;
    len_next     = len_reg;
    cap_len_next = cap_len_reg;
    wr_ptr_next  = wr_ptr_reg;
    done_next    = done_reg;
    cnt_end_next = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = wr_ptr_reg;

    // Abort wins over everything, including a pending trigger write.
    if (bus.cfg_abort) begin
      state_next = ST_IDLE;
      done_next  = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (bus.cfg_start) begin
            state_next   = ST_ARMED;
            count_next   = '0;
            wr_ptr_next  = '0;
            cap_len_next = '0;
            done_next    = 1'b0;
            trig_next    = bus.cfg_trig_val;
            len_next     = (bus.cfg_len == '0) ? LEN_MAX : bus.cfg_len;
          end
        end
        ST_ARMED: begin
          count_next   = count_reg + 1'b1;
          cnt_end_next = &count_reg;
          if (count_reg == trig_reg) begin
            wr_en        = 1'b1;
            wr_addr      = '0;
            wr_ptr_next  = PTR_ONE;
            cap_len_next = LEN_ONE;
            if (len_reg == LEN_ONE) begin
              state_next = ST_DONE;
              done_next  = 1'b1;
            end else begin
              state_next = ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          count_next   = count_reg + 1'b1;
          cnt_end_next = &count_reg;
          wr_en        = 1'b1;
          wr_ptr_next  = wr_ptr_reg + 1'b1;
          cap_len_next = cap_len_inc;
          if (cap_len_inc == len_reg) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      count_reg   <= '0;
      trig_reg    <= '0;
      len_reg     <= LEN_MAX;
      cap_len_reg <= '0;
      wr_ptr_reg  <= '0;
      done_reg    <= 1'b0;
      cnt_end_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      trig_reg    <= trig_next;
      len_reg     <= len_next;
      cap_len_reg <= cap_len_next;
      wr_ptr_reg  <= wr_ptr_next;
      done_reg    <= done_next;
      cnt_end_reg <= cnt_end_next;
    end
  end

  // Memory array is left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= count_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= bus.rd_en;
      if (bus.rd_en) begin
        rd_data_reg <= mem[bus.rd_addr];
      end
    end
  end

  assign bus.rd_data  = rd_data_reg;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.count    = count_reg;
  assign bus.cap_len  = cap_len_reg;
  assign bus.busy     = (state_reg == ST_ARMED) || (state_reg == ST_CAPTURE);
  assign bus.done     = done_reg;
  assign bus.cnt_end  = cnt_end_reg;
endmodule

// File: tb/tb_count_capture_ctrl.sv
// Randomized bench for count_capture_ctrl: a timeline model predicts counter,
// status and captured data from (trigger, length, start time) arithmetic.
module tb_count_capture_ctrl;
  localparam int CNT_W = 8;
  localparam int DEPTH = 16;
  localparam int PTR_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  count_capture_ctrl_if #(.CNT_W(CNT_W), .PTR_W(PTR_W)) bus ();

  count_capture_ctrl #(.CNT_W(CNT_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int model_mem [DEPTH];
  bit model_wr  [DEPTH];
  int exp_rd = 0;
  bit exp_rd_known = 1'b1;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One clock: issue a read (random or forced), advance, apply the model write
  // that lands on this edge, then check the read port. Old data is captured
  // before the write so same-address collisions expect read-before-write.
  task automatic tick(input int rd_mode, input int faddr,
                      input bit mw_en, input int mw_idx, input int mw_val);
    bit ren;
    int addr;
    int pend;
    bit pend_known;
    ren  = (rd_mode == 1) ? 1'b1 : ($urandom_range(0, 1) == 1);
    addr = (rd_mode == 1) ? faddr : int'($urandom_range(0, DEPTH-1));
    bus.rd_en   = ren;
    bus.rd_addr = PTR_W'(addr);
    pend       = model_mem[addr];
    pend_known = model_wr[addr];
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    if (mw_en) begin
      model_mem[mw_idx] = mw_val;
      model_wr[mw_idx]  = 1'b1;
    end
    check_val("rd_valid", int'(bus.rd_valid), int'(ren));
    if (ren) begin
      exp_rd       = pend;
      exp_rd_known = pend_known;
    end
    if (exp_rd_known) check_val("rd_data", int'(bus.rd_data), exp_rd);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_count"},    int'(bus.count),    0);
    check_val({tag, "_cap_len"},  int'(bus.cap_len),  0);
    check_val({tag, "_busy"},     int'(bus.busy),     0);
    check_val({tag, "_done"},     int'(bus.done),     0);
    check_val({tag, "_rd_valid"}, int'(bus.rd_valid), 0);
    check_val({tag, "_rd_data"},  int'(bus.rd_data),  0);
    check_val({tag, "_cnt_end"},  int'(bus.cnt_end),  0);
  endtask

  task automatic mid_reset();
    #3 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    exp_rd = 0;
    exp_rd_known = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1'b0, 0, 0);
      check_val("post_rst_count", int'(bus.count), 0);
      check_val("post_rst_busy",  int'(bus.busy),  0);
      check_val("post_rst_done",  int'(bus.done),  0);
    end
  endtask

  // After the start edge, cycle j sees count=j mod 256, writes land on edges
  // trig+1..trig+len, and the capture completes at j = trig+len.
  task automatic run_capture(input int trig, input int len_cfg, input int abort_w,
                             input bit poke_start, input int rst_j);
    int len;
    len = (len_cfg == 0) ? DEPTH : len_cfg;
    $display("capture trig=%0d len=%0d abort_w=%0d poke=%0d rst_j=%0d",
             trig, len_cfg, abort_w, poke_start, rst_j);
    bus.cfg_start    = 1'b1;
    bus.cfg_trig_val = CNT_W'(trig);
    bus.cfg_len      = (PTR_W+1)'(len_cfg);
    tick(0, 0, 1'b0, 0, 0);
    bus.cfg_start    = 1'b0;
    bus.cfg_trig_val = CNT_W'($urandom);
    bus.cfg_len      = (PTR_W+1)'($urandom);
    for (int j = 0; j <= trig + len; j++) begin
      check_val("count",   int'(bus.count),   j % 256);
      check_val("busy",    int'(bus.busy),    int'(j < trig + len));
      check_val("done",    int'(bus.done),    int'(j >= trig + len));
      check_val("cap_len", int'(bus.cap_len), (j > trig) ? j - trig : 0);
      check_val("cnt_end", int'(bus.cnt_end), int'(j > 0 && j % 256 == 0));
      if (j == trig + len) break;
      if (rst_j == j) begin
        mid_reset();
        return;
      end
      if (abort_w > 0 && j - trig == abort_w) begin
        bus.cfg_abort = 1'b1;
        tick(0, 0, 1'b0, 0, 0);
        bus.cfg_abort = 1'b0;
        check_val("abort_busy",    int'(bus.busy),    0);
        check_val("abort_done",    int'(bus.done),    0);
        check_val("abort_count",   int'(bus.count),   j % 256);
        check_val("abort_cap_len", int'(bus.cap_len), abort_w);
        for (int i = 0; i < abort_w; i++) begin
          tick(1, i, 1'b0, 0, 0);
          check_val("abort_readback", int'(bus.rd_data), (trig + i) % 256);
        end
        return;
      end
      if (poke_start && j == 1) begin
        bus.cfg_start    = 1'b1;
        bus.cfg_trig_val = CNT_W'(trig + 7);
        bus.cfg_len      = (PTR_W+1)'(len % DEPTH + 1);
      end
      tick(0, 0, j >= trig, j - trig, j % 256);
      bus.cfg_start = 1'b0;
    end
    for (int i = 0; i < len; i++) begin
      tick(1, i, 1'b0, 0, 0);
      check_val("readback",    int'(bus.rd_data), (trig + i) % 256);
      check_val("hold_count",  int'(bus.count),   (trig + len) % 256);
      check_val("hold_caplen", int'(bus.cap_len), len);
    end
  endtask

  initial begin
    bus.cfg_start    = 1'b0;
    bus.cfg_abort    = 1'b0;
    bus.cfg_trig_val = '0;
    bus.cfg_len      = '0;
    bus.rd_en        = 1'b0;
    bus.rd_addr      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = 0;
      model_wr[i]  = 1'b0;
    end
    #12 check_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick(0, 0, 1'b0, 0, 0);
    check_val("idle_count", int'(bus.count), 0);
    check_val("idle_busy",  int'(bus.busy),  0);

    run_capture(10, 4, -1, 1'b0, -1);
    run_capture(254, 0, -1, 1'b0, -1);
    run_capture(0, 1, -1, 1'b0, -1);
    run_capture(5, 8, 2, 1'b0, -1);
    run_capture(3, 2, -1, 1'b0, -1);
    run_capture(20, 3, -1, 1'b1, -1);

    // Simultaneous start and abort from DONE: abort wins, nothing restarts.
    $display("arbitration start+abort");
    bus.cfg_start    = 1'b1;
    bus.cfg_abort    = 1'b1;
    bus.cfg_trig_val = 8'd1;
    bus.cfg_len      = 5'd2;
    tick(0, 0, 1'b0, 0, 0);
    bus.cfg_start = 1'b0;
    bus.cfg_abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_val("arb_busy",  int'(bus.busy),    0);
      check_val("arb_done",  int'(bus.done),    0);
      check_val("arb_count", int'(bus.count),   23);
      check_val("arb_cap",   int'(bus.cap_len), 3);
      tick(0, 0, 1'b0, 0, 0);
    end

    run_capture(40, 6, -1, 1'b0, 43);

    for (int r = 0; r < 12; r++) begin
      int t;
      int l;
      int ln;
      int a;
      t  = int'($urandom_range(0, 255));
      l  = int'($urandom_range(0, DEPTH));
      ln = (l == 0) ? DEPTH : l;
      a  = ($urandom_range(0, 3) == 0 && ln > 1) ? int'($urandom_range(1, ln - 1)) : -1;
      run_capture(t, l, a, $urandom_range(0, 1) == 1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
